// File: rtl/rfw_writeback_stage.sv
// RF-write stage of the pipelined Beta: MEM/WB register, write-data select and
// a 2**ADDR_WIDTH-entry register file with write-through bypass on both read ports.
module rfw_writeback_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_pc_plus4,
    input  logic [DATA_WIDTH-1:0] mem_alu,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [ADDR_WIDTH-1:0] mem_rc,
    input  logic [1:0]            mem_wdsel,
    input  logic                  mem_werf,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_rc,
    output logic [DATA_WIDTH-1:0] wb_data
);

    localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] R31 = '1;

    logic                  wb_valid_q;
    logic                  wb_we_q;
    logic [ADDR_WIDTH-1:0] wb_rc_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [DATA_WIDTH-1:0] wb_data_d;
    logic                  wb_we_d;
    logic [DATA_WIDTH-1:0] regfile_q [NumRegs];

    always_comb begin
        wb_data_d = mem_rdata;
        case (mem_wdsel)
            2'b00:   wb_data_d = mem_pc_plus4;
            2'b01:   wb_data_d = mem_alu;
            default: wb_data_d = mem_rdata;
        endcase
    end

    // R31 is hard-wired zero, so a write to it is squashed before it reaches WB.
    assign wb_we_d = mem_valid & mem_werf & (mem_rc != R31);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rc_q    <= R31;
            wb_data_q  <= '0;
            for (int i = 0; i < int'(NumRegs); i++) begin
                regfile_q[i] <= '0;
            end
        end else begin
            wb_valid_q <= mem_valid;
            wb_we_q    <= wb_we_d;
            wb_rc_q    <= mem_rc;
            wb_data_q  <= wb_data_d;
            if (wb_we_q) begin
                regfile_q[wb_rc_q] <= wb_data_q;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        if (addr == R31) begin
            val = '0;
        end else if (wb_we_q && (addr == wb_rc_q)) begin
            val = wb_data_q;
        end else begin
            val = regfile_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        rd1 = rf_read(ra1);
        rd2 = rf_read(ra2);
    end

    assign wb_valid = wb_valid_q;
    assign wb_we    = wb_we_q;
    assign wb_rc    = wb_rc_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_rfw_writeback_stage.sv
// Randomised and directed bench for rfw_writeback_stage; the model treats a write
// as architecturally visible from the cycle it enters WB and clears on reset.
module tb_rfw_writeback_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc_plus4 = '0;
    logic [31:0] mem_alu = '0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  mem_rc = '0;
    logic [1:0]  mem_wdsel = '0;
    logic        mem_werf = 1'b0;
    logic [4:0]  ra1 = '0;
    logic [4:0]  ra2 = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rc;
    logic [31:0] wb_data;

    int checks = 0;
    int fails = 0;

    // Model state: architectural register values plus the expected WB-register contents.
    logic [31:0] ref_rf [32];
    logic        exp_valid;
    logic        exp_we;
    logic [4:0]  exp_rc;
    logic [31:0] exp_data;

    rfw_writeback_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_valid    (mem_valid),
        .mem_pc_plus4 (mem_pc_plus4),
        .mem_alu      (mem_alu),
        .mem_rdata    (mem_rdata),
        .mem_rc       (mem_rc),
        .mem_wdsel    (mem_wdsel),
        .mem_werf     (mem_werf),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd1          (rd1),
        .rd2          (rd2),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rc        (wb_rc),
        .wb_data      (wb_data)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd31) ? 32'd0 : ref_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        exp_valid = 1'b0;
        exp_we    = 1'b0;
        exp_rc    = 5'd31;
        exp_data  = '0;
    endtask

    // Present one MEM-stage instruction, clock it into WB and advance the model.
    task automatic issue(input logic v, input logic [1:0] sel, input logic we,
                         input logic [4:0] rc, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic rst);
        mem_valid = v; mem_wdsel = sel; mem_werf = we; mem_rc = rc;
        mem_pc_plus4 = pc; mem_alu = alu; mem_rdata = rdat; reset = rst;
        @(posedge clk);
        #1;
        reset = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            exp_valid = v;
            exp_we    = v && we && (rc != 5'd31);
            exp_rc    = rc;
            exp_data  = (sel == 2'b00) ? pc : (sel == 2'b01) ? alu : rdat;
            if (exp_we) ref_rf[rc] = exp_data;
        end
    endtask

    task automatic test_reset();
        issue(1'b1, 2'b01, 1'b1, 5'd9, 32'h1, 32'h55, 32'h2, 1'b1);
        checks++;
        if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_rc !== 5'd31) begin
            fails++;
            $display("FAIL reset_wb: valid=%b we=%b rc=%0d, want 0 0 31", wb_valid, wb_we, wb_rc);
        end
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                fails++;
                $display("FAIL reset_read a=%0d: rd1=%h rd2=%h, want 0", a, rd1, rd2);
            end
        end
    endtask

    task automatic test_op_write();
        issue(1'b1, 2'b01, 1'b1, 5'd5, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
        ra1 = 5'd5;
        #1;
        checks++;
        if (wb_we !== 1'b1 || wb_data !== 32'h1234_5678 || rd1 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL op_bypass: we=%b data=%h rd1=%h, want 1 12345678 12345678",
                     wb_we, wb_data, rd1);
        end
        issue(1'b0, 2'b01, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        ra1 = 5'd5;
        #1;
        checks++;
        if (rd1 !== 32'h1234_5678 || wb_we !== 1'b0) begin
            fails++;
            $display("FAIL op_storage: rd1=%h we=%b, want 12345678 0", rd1, wb_we);
        end
    endtask

    task automatic test_ld_br();
        issue(1'b1, 2'b10, 1'b1, 5'd3, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 2'b00, 1'b1, 5'd4, 32'h0000_0104, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 2'b11, 1'b1, 5'd6, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        ra1 = 5'd3; ra2 = 5'd4;
        #1;
        checks++;
        if (rd1 !== 32'hDEAD_BEEF || rd2 !== 32'h0000_0104) begin
            fails++;
            $display("FAIL ld_br: r3=%h r4=%h, want deadbeef 00000104", rd1, rd2);
        end
        ra1 = 5'd6;
        #1;
        checks++;
        if (rd1 !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL wdsel11: r6=%h, want cafef00d", rd1);
        end
    endtask

    task automatic test_st_bubble();
        issue(1'b1, 2'b01, 1'b0, 5'd7, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        checks++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL st_we: we=%b valid=%b, want 0 1", wb_we, wb_valid);
        end
        issue(1'b0, 2'b01, 1'b1, 5'd8, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        checks++;
        if (wb_we !== 1'b0 || wb_valid !== 1'b0) begin
            fails++;
            $display("FAIL bubble_we: we=%b valid=%b, want 0 0", wb_we, wb_valid);
        end
        issue(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        ra1 = 5'd7; ra2 = 5'd8;
        #1;
        checks++;
        if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
            fails++;
            $display("FAIL st_bubble_regs: r7=%h r8=%h, want 0 0", rd1, rd2);
        end
    endtask

    task automatic test_r31();
        for (int c = 0; c < 3; c++) begin
            issue(c < 2, 2'b01, 1'b1, 5'd31, 32'h0, 32'hAAAA_AAAA, 32'h0, 1'b0);
            ra1 = 5'd31; ra2 = 5'd31;
            #1;
            checks++;
            if (wb_we !== 1'b0 || rd1 !== 32'd0 || rd2 !== 32'd0) begin
                fails++;
                $display("FAIL r31 c=%0d: we=%b rd1=%h rd2=%h, want 0 0 0", c, wb_we, rd1, rd2);
            end
        end
    endtask

    task automatic test_back_to_back_reset();
        issue(1'b1, 2'b01, 1'b1, 5'd2, 32'h0, 32'd1, 32'h0, 1'b0);
        ra1 = 5'd2; ra2 = 5'd2;
        #1;
        checks++;
        if (rd1 !== 32'd1 || rd2 !== 32'd1) begin
            fails++;
            $display("FAIL b2b_first: rd1=%h rd2=%h, want 1 1", rd1, rd2);
        end
        issue(1'b1, 2'b01, 1'b1, 5'd2, 32'h0, 32'd2, 32'h0, 1'b0);
        #1;
        checks++;
        if (rd1 !== 32'd2 || wb_we !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: rd1=%h we=%b, want 2 1", rd1, wb_we);
        end
        issue(1'b1, 2'b01, 1'b1, 5'd2, 32'h0, 32'd3, 32'h0, 1'b1);
        #1;
        checks++;
        if (rd1 !== 32'd0 || wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            fails++;
            $display("FAIL b2b_reset: r2=%h valid=%b we=%b, want 0 0 0", rd1, wb_valid, wb_we);
        end
    endtask

    task automatic test_random();
        logic [4:0] rc;
        for (int n = 0; n < 400; n++) begin
            rc = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            issue($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 3) != 0, rc,
                  $urandom, $urandom, $urandom, $urandom_range(0, 40) == 0);
            checks++;
            if (wb_valid !== exp_valid || wb_we !== exp_we ||
                (exp_valid && (wb_rc !== exp_rc || wb_data !== exp_data))) begin
                fails++;
                $display("FAIL rand_wb n=%0d: v/we/rc/d=%b %b %0d %h, want %b %b %0d %h", n,
                         wb_valid, wb_we, wb_rc, wb_data, exp_valid, exp_we, exp_rc, exp_data);
            end
            ra1 = rc; ra2 = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2)) begin
                fails++;
                $display("FAIL rand_read n=%0d: rd1[%0d]=%h rd2[%0d]=%h, want %h %h", n,
                         ra1, rd1, ra2, rd2, exp_rd(ra1), exp_rd(ra2));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_op_write();
        test_ld_br();
        test_st_bubble();
        test_r31();
        test_back_to_back_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
